// File: rtl/data_mem_pkg.sv
// Shared sizing for the byte-lane data RAM, also used by the execute stage.
// Holds the clear-sweep state encoding used when DATA_MEM_CLEAR_EN is defined.
package data_mem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 256;

  typedef enum logic {
    IDLE,
    SWEEP
  } clear_state_t;

endpackage

// File: rtl/data_mem_clear_fsm.sv
// Address sweeper that zeroes every RAM location after reset.
// Only instantiated by data_mem when DATA_MEM_CLEAR_EN is defined.
module data_mem_clear_fsm #(
  parameter int ADDR_W = data_mem_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] sweep_addr,
  output logic              busy,
  output logic              hold
);

  import data_mem_pkg::*;

  clear_state_t      state;
  clear_state_t      state_nxt;
  logic [ADDR_W-1:0] sweep_cnt;
  logic [ADDR_W-1:0] sweep_cnt_nxt;
  logic              start_pend;
  logic              start_pend_nxt;

  // Reset only arms the sweep; busy stays low until the first cycle out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sweep_cnt  <= '0;
      start_pend <= 1'b1;
    end else begin
      state      <= state_nxt;
      sweep_cnt  <= sweep_cnt_nxt;
      start_pend <= start_pend_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    sweep_cnt_nxt  = sweep_cnt;
    start_pend_nxt = start_pend;
    case (state)
      IDLE: begin
        if (start_pend) begin
          state_nxt      = SWEEP;
          start_pend_nxt = 1'b0;
          sweep_cnt_nxt  = '0;
        end
      end
      SWEEP: begin
        sweep_cnt_nxt = sweep_cnt + 1'b1;
        if (sweep_cnt == '1) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign sweep_addr = sweep_cnt;
  assign busy       = (state == SWEEP);
  // The armed cycle is treated like the sweep so nothing stale leaks out of q.
  assign hold       = busy | start_pend;

endmodule

// File: rtl/data_mem.sv
// One byte lane of the CPU data memory: 256 x 8, single port, registered read.
// Define DATA_MEM_CLEAR_EN to zero the whole array after every reset.
module data_mem #(
  parameter int ADDR_W = data_mem_pkg::ADDR_W,
  parameter int DATA_W = data_mem_pkg::DATA_W,
  parameter int DEPTH  = data_mem_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q,
  output logic              busy
);

  import data_mem_pkg::*;

  logic [DATA_W-1:0] mem [DEPTH];

`ifdef DATA_MEM_CLEAR_EN
  logic [ADDR_W-1:0] sweep_addr;
  logic              sweep_busy;
  logic              sweep_hold;

  data_mem_clear_fsm #(
    .ADDR_W(ADDR_W)
  ) u_clear_fsm (
    .clk       (clk),
    .rst       (rst),
    .sweep_addr(sweep_addr),
    .busy      (sweep_busy),
    .hold      (sweep_hold)
  );

  assign busy = sweep_busy;

  // The sweep owns the write port; external stores are dropped while it runs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (sweep_busy) begin
        mem[sweep_addr] <= '0;
      end else if (!sweep_hold && !wren) begin
        mem[address] <= data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || sweep_hold) begin
      q <= '0;
    end else if (!wren) begin
      q <= data;
    end else begin
      q <= mem[address];
    end
  end
`else
  assign busy = 1'b0;

  // wren is active-low: a lane stores only when its enable is pulled to 0.
  always_ff @(posedge clk) begin
    if (!rst && !wren) begin
      mem[address] <= data;
    end
  end

  // Write-through keeps a store's byte visible on q without a second access.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (!wren) begin
      q <= data;
    end else begin
      q <= mem[address];
    end
  end
`endif

endmodule

// File: tb/tb_data_mem.sv
// Four-lane bench for data_mem with a word-level reference model and result queue.
// The clear-sweep checks compile in when DATA_MEM_CLEAR_EN is defined.
module tb_data_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  address;
  logic [31:0] data;
  logic [3:0]  wren;
  logic [31:0] q;
  logic [3:0]  busy;

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_lane
      data_mem dut (
        .clk    (clk),
        .rst    (rst),
        .address(address),
        .data   (data[8*g +: 8]),
        .wren   (wren[g]),
        .q      (q[8*g +: 8]),
        .busy   (busy[g])
      );
    end
  endgenerate

  logic [31:0] model [256];
  logic [31:0] exp_q [$];
  int vectors     = 0;
  int miscompares = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // One clock of stimulus; the expected q is queued when driven and checked after the edge.
  task automatic applyStimulus(input string tag, input logic r, input logic [3:0] wn,
                               input logic [7:0] a, input logic [31:0] d);
    logic [31:0] e;
    rst     = r;
    wren    = wn;
    address = a;
    data    = d;
    e       = '0;
    for (int i = 0; i < 4; i++) begin
      if (r) begin
        e[8*i +: 8] = 8'h00;
      end else if (!wn[i]) begin
        e[8*i +: 8]        = d[8*i +: 8];
        model[a][8*i +: 8] = d[8*i +: 8];
      end else begin
        e[8*i +: 8] = model[a][8*i +: 8];
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    checkOutput(tag, q, exp_q.pop_front());
    checkOutput({tag, "_busy"}, {28'd0, busy}, 32'd0);
  endtask

`ifdef DATA_MEM_CLEAR_EN
  task automatic waitSweep(input string tag);
    int count;
    int q_bad;
    count = 0;
    q_bad = 0;
    rst   = 1'b0;
    wren  = 4'hF;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      if (busy == 4'hF) begin
        count++;
        if (q !== 32'd0) q_bad++;
      end else if (count > 0) begin
        break;
      end
    end
    checkOutput(tag, count, 32'd256);
    checkOutput({tag, "_q_held"}, q_bad, 32'd0);
    for (int i = 0; i < 256; i++) model[i] = 32'd0;
  endtask
`endif

  task automatic doReset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      applyStimulus("reset_q", 1'b1, 4'h0, 8'd5, 32'hAAAA_AAAA);
    end
`ifdef DATA_MEM_CLEAR_EN
    waitSweep("sweep_len");
`endif
  endtask

  initial begin
    rst     = 1'b1;
    wren    = 4'hF;
    address = '0;
    data    = '0;
    for (int i = 0; i < 256; i++) model[i] = 32'd0;

    doReset(1);

    // Contents written before reset survive it unless the clear sweep is built in.
    applyStimulus("wr_addr5", 1'b0, 4'h0, 8'd5, 32'h7777_7777);
    doReset(2);
    applyStimulus("rd_addr5", 1'b0, 4'hF, 8'd5, 32'h0);
    checkOutput("addr5_not_aa", {31'd0, q === 32'hAAAA_AAAA}, 32'd0);

    applyStimulus("wr_10", 1'b0, 4'h0, 8'h10, 32'h3C3C_3C3C);
    applyStimulus("rd_10", 1'b0, 4'hF, 8'h10, 32'h0);

    applyStimulus("wr_07", 1'b0, 4'h0, 8'h07, 32'h0101_0101);
    applyStimulus("nowr_07", 1'b0, 4'hF, 8'h07, 32'hFFFF_FFFF);
    applyStimulus("rd_07", 1'b0, 4'hF, 8'h07, 32'h0);
    checkOutput("rd_07_const", q, 32'h0101_0101);

    applyStimulus("wr_03", 1'b0, 4'h0, 8'h03, 32'h1122_3344);
    applyStimulus("half_03", 1'b0, 4'b1100, 8'h03, 32'hAABB_CCDD);
    applyStimulus("rd_03", 1'b0, 4'hF, 8'h03, 32'h0);
    checkOutput("rd_03_const", q, 32'h1122_CCDD);

    applyStimulus("wr_00", 1'b0, 4'h0, 8'h00, 32'h5A5A_5A5A);
    applyStimulus("wr_ff", 1'b0, 4'h0, 8'hFF, 32'hA5A5_A5A5);
    applyStimulus("rd_00", 1'b0, 4'hF, 8'h00, 32'h0);
    applyStimulus("rd_ff", 1'b0, 4'hF, 8'hFF, 32'h0);

    applyStimulus("b2b_wr1", 1'b0, 4'h0, 8'h09, 32'h1212_1212);
    applyStimulus("b2b_wr2", 1'b0, 4'h0, 8'h09, 32'h3434_3434);
    applyStimulus("b2b_rd", 1'b0, 4'hF, 8'h09, 32'h0);
    applyStimulus("alt_wr", 1'b0, 4'h0, 8'h09, 32'h5656_5656);
    applyStimulus("alt_rd", 1'b0, 4'hF, 8'h09, 32'h0);

    // Random mixed traffic confined to a prefilled window so every read is defined.
    for (int i = 0; i < 16; i++) begin
      applyStimulus("prefill", 1'b0, 4'h0, 8'h40 + 8'(i), $urandom);
    end
    for (int i = 0; i < 48; i++) begin
      applyStimulus("random", 1'b0, 4'($urandom_range(0, 15)),
                    8'h40 + 8'($urandom_range(0, 15)), $urandom);
    end

`ifdef DATA_MEM_CLEAR_EN
    applyStimulus("mid_rst", 1'b1, 4'hF, 8'd0, 32'h0);
    rst  = 1'b0;
    wren = 4'hF;
    for (int i = 0, n = 0; i < 200 && n < 100; i++) begin
      @(posedge clk);
      #1;
      if (busy == 4'hF) n++;
    end
    doReset(1);
    for (int i = 0; i < 256; i++) begin
      applyStimulus("cleared", 1'b0, 4'hF, 8'(i), 32'h0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
